// File: rtl/bmp180_pkg.sv
// Shared types and constants for the BMP180 BCD display path: FSM encoding, digit count,
// and the active-low gfedcba segment table.
package bmp180_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned N_DIGITS = 6;
  localparam int unsigned BCD_W    = 4 * N_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low gfedcba; anything that is not a decimal digit is drawn blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction step: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder (gfedcba).
module bcd_to_7seg
  import bmp180_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = digit_to_seg(digit_i);

endmodule

// File: rtl/bmp180_bcd_display.sv
// Converts a signed BMP180 temperature or pressure into six BCD digits with a sequential
// double-dabble engine and drives six active-low 7-segment displays with sign and blanking.
module bmp180_bcd_display
  import bmp180_pkg::*;
#(
  parameter bit          LZ_BLANK = 1'b1,
  parameter int unsigned N_BITS   = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              sel_i,
  input  logic [15:0]       t_value_i,
  input  logic [N_BITS-1:0] p_value_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sign_o,
  output logic [BCD_W-1:0]  bcd_o,
  output logic [6:0]        hex0_o,
  output logic [6:0]        hex1_o,
  output logic [6:0]        hex2_o,
  output logic [6:0]        hex3_o,
  output logic [6:0]        hex4_o,
  output logic [6:0]        hex5_o
);

  localparam int unsigned CntW = $clog2(N_BITS);

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [N_BITS-1:0]         mag_q, mag_d;
  logic [BCD_W-1:0]          acc_q, acc_d;
  logic                      sign_pend_q, sign_pend_d;
  logic                      sign_q, sign_d;
  logic [BCD_W-1:0]          bcd_q, bcd_d;
  logic                      done_q, done_d;
  logic [N_DIGITS-1:0][6:0]  hex_q, hex_d;

  logic [N_BITS-1:0]         operand;
  logic [N_BITS-1:0]         magnitude;
  logic [N_DIGITS-1:0][6:0]  seg_raw;
  logic [N_DIGITS-1:0][6:0]  hex_new;
  logic [2:0]                msd;

  // Temperature is sign-extended; the most negative operand maps onto itself as unsigned.
  assign operand   = sel_i ? p_value_i : {{(N_BITS-16){t_value_i[15]}}, t_value_i};
  assign magnitude = operand[N_BITS-1] ? (~operand + 1'b1) : operand;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    bcd_to_7seg u_dec (
      .digit_i(acc_q[4*g +: 4]),
      .seg_o  (seg_raw[g])
    );
  end

  // Display image of the finished accumulator, with leading-zero blanking and minus.
  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (acc_q[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      hex_new[i] = seg_raw[i];
      if (LZ_BLANK && (3'(i) > msd)) hex_new[i] = SEG_BLANK;
    end
    if (sign_pend_q) begin
      if (LZ_BLANK) begin
        if (msd < 3'(N_DIGITS - 1)) hex_new[msd + 3'd1] = SEG_MINUS;
      end else if (acc_q[BCD_W-1 -: 4] == 4'd0) begin
        hex_new[N_DIGITS-1] = SEG_MINUS;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StShift;
      StShift: if (cnt_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    sign_pend_d = sign_pend_q;
    sign_d      = sign_q;
    bcd_d       = bcd_q;
    hex_d       = hex_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sign_pend_d = operand[N_BITS-1];
          mag_d       = magnitude;
          acc_d       = '0;
          cnt_d       = CntW'(N_BITS - 1);
        end
      end
      StShift: begin
        {acc_d, mag_d} = {bcd_add3(acc_q), mag_q} << 1;
        cnt_d          = cnt_q - 1'b1;
      end
      StDone: begin
        bcd_d  = acc_q;
        sign_d = sign_pend_q;
        hex_d  = hex_new;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      mag_q       <= '0;
      acc_q       <= '0;
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
      bcd_q       <= '0;
      done_q      <= 1'b0;
      hex_q       <= {N_DIGITS{SEG_BLANK}};
    end else begin
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      sign_pend_q <= sign_pend_d;
      sign_q      <= sign_d;
      bcd_q       <= bcd_d;
      done_q      <= done_d;
      hex_q       <= hex_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign sign_o = sign_q;
  assign bcd_o  = bcd_q;
  assign hex0_o = hex_q[0];
  assign hex1_o = hex_q[1];
  assign hex2_o = hex_q[2];
  assign hex3_o = hex_q[3];
  assign hex4_o = hex_q[4];
  assign hex5_o = hex_q[5];

endmodule

// File: tb/tb_bmp180_bcd_display.sv
// Self-checking bench for bmp180_bcd_display: table vectors, random values against a
// decimal-arithmetic model, and hand sequences for reset abort and start handling.
module tb_bmp180_bcd_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sel;
  logic [15:0] t_val;
  logic [18:0] p_val;

  logic        busy, done, sign;
  logic [23:0] bcd;
  logic [6:0]  h0, h1, h2, h3, h4, h5;
  logic        busy_n, done_n, sign_n;
  logic [23:0] bcd_n;
  logic [6:0]  n0, n1, n2, n3, n4, n5;

  int checks = 0;
  int errors = 0;

  bmp180_bcd_display #(.LZ_BLANK(1'b1), .N_BITS(19)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sel_i(sel), .t_value_i(t_val),
    .p_value_i(p_val), .busy_o(busy), .done_o(done), .sign_o(sign), .bcd_o(bcd),
    .hex0_o(h0), .hex1_o(h1), .hex2_o(h2), .hex3_o(h3), .hex4_o(h4), .hex5_o(h5)
  );

  bmp180_bcd_display #(.LZ_BLANK(1'b0), .N_BITS(19)) dut_nlz (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sel_i(sel), .t_value_i(t_val),
    .p_value_i(p_val), .busy_o(busy_n), .done_o(done_n), .sign_o(sign_n), .bcd_o(bcd_n),
    .hex0_o(n0), .hex1_o(n1), .hex2_o(n2), .hex3_o(n3), .hex4_o(n4), .hex5_o(n5)
  );

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] Blank = 7'b1111111;
  localparam logic [6:0] Minus = 7'b0111111;

  typedef struct {
    logic        sel;
    logic [15:0] t;
    logic [18:0] p;
    logic [23:0] bcd;
    logic        sign;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference display image built from decimal digits of the magnitude.
  function automatic logic [41:0] model_hex(input int mag, input bit neg, input bit lz);
    int d[6];
    int msd;
    int div;
    logic [41:0] r;
    div = 1;
    msd = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = (mag / div) % 10;
      div  = div * 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < 6; i++) begin
      r[7*i +: 7] = (lz && i > msd) ? Blank : seg_tab[d[i]];
    end
    if (neg) begin
      if (lz) begin
        if (msd < 5) r[7*(msd+1) +: 7] = Minus;
      end else if (d[5] == 0) begin
        r[35 +: 7] = Minus;
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] model_bcd(input int mag);
    logic [23:0] r;
    int div;
    div = 1;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((mag / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  task automatic run_conv(input bit s, input logic [15:0] t, input logic [18:0] p,
                          input string tag);
    int v, mag, lat;
    bit neg;
    v   = s ? int'($signed(p)) : int'($signed(t));
    neg = (v < 0);
    mag = neg ? -v : v;
    @(posedge clk); #1;
    sel = s; t_val = t; p_val = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sel = 1'($urandom); t_val = 16'($urandom); p_val = 19'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd20);
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " bcd"}, 64'(bcd), 64'(model_bcd(mag)));
    check({tag, " sign"}, 64'(sign), 64'(neg));
    check({tag, " hex lz"}, 64'({h5, h4, h3, h2, h1, h0}), 64'(model_hex(mag, neg, 1'b1)));
    check({tag, " hex nlz"}, 64'({n5, n4, n3, n2, n1, n0}), 64'(model_hex(mag, neg, 1'b0)));
    check({tag, " nlz bcd"}, 64'(bcd_n), 64'(model_bcd(mag)));
    @(posedge clk); #1;
    check({tag, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_done, first_c, second_c;
    logic [23:0] b20;
    logic s20;

    vecs[0]  = '{1'b0, 16'd250,        19'd0,           24'h000250, 1'b0};
    vecs[1]  = '{1'b0, 16'(-15),       19'd0,           24'h000015, 1'b1};
    vecs[2]  = '{1'b1, 16'd0,          19'd101325,      24'h101325, 1'b0};
    vecs[3]  = '{1'b1, 16'd0,          19'(-262144),    24'h262144, 1'b1};
    vecs[4]  = '{1'b0, 16'd0,          19'd0,           24'h000000, 1'b0};
    vecs[5]  = '{1'b0, 16'(-32768),    19'd0,           24'h032768, 1'b1};
    vecs[6]  = '{1'b0, 16'd32767,      19'd0,           24'h032767, 1'b0};
    vecs[7]  = '{1'b1, 16'd0,          19'd262143,      24'h262143, 1'b0};
    vecs[8]  = '{1'b1, 16'd0,          19'(-1),         24'h000001, 1'b1};
    vecs[9]  = '{1'b1, 16'd0,          19'(-100000),    24'h100000, 1'b1};
    vecs[10] = '{1'b1, 16'd0,          19'(-99999),     24'h099999, 1'b1};

    rst = 1'b1; start = 1'b0; sel = 1'b0; t_val = '0; p_val = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sign", 64'(sign), 64'd0);
    check("reset bcd", 64'(bcd), 64'd0);
    check("reset hex", 64'({h5, h4, h3, h2, h1, h0}), {22'd0, {6{Blank}}});
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_conv(vecs[i].sel, vecs[i].t, vecs[i].p, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table bcd", i), 64'(bcd), 64'(vecs[i].bcd));
      check($sformatf("vec%0d table sign", i), 64'(sign), 64'(vecs[i].sign));
    end

    // Reset eight edges into a conversion must abort it and clear all outputs.
    @(posedge clk); #1;
    sel = 1'b1; p_val = 19'd123456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort bcd", 64'(bcd), 64'd0);
    check("abort sign", 64'(sign), 64'd0);
    check("abort hex", 64'({h5, h4, h3, h2, h1, h0}), {22'd0, {6{Blank}}});
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'd0);

    // Starts at k+5 and k+20 are ignored; the one at k+21 is accepted.
    @(posedge clk); #1;
    sel = 1'b1; p_val = 19'(-5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; first_c = -1; second_c = -1; b20 = '0; s20 = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      start = (c == 5 || c == 20 || c == 21);
      sel   = 1'b0;
      t_val = (c == 21) ? 16'd777 : 16'd999;
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (first_c < 0) begin
          first_c = c; b20 = bcd; s20 = sign;
        end else if (second_c < 0) begin
          second_c = c;
        end
      end
    end
    start = 1'b0;
    check("b2b done count", 64'(n_done), 64'd2);
    check("b2b first done", 64'(first_c), 64'd20);
    check("b2b second done", 64'(second_c), 64'd41);
    check("b2b first bcd", 64'(b20), 64'h5);
    check("b2b first sign", 64'(s20), 64'd1);
    check("b2b second bcd", 64'(bcd), 64'h777);
    check("b2b second sign", 64'(sign), 64'd0);

    for (int i = 0; i < 40; i++) begin
      run_conv(1'($urandom), 16'($urandom), 19'($urandom), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmp180_bcd_display.md
Name: bmp180_bcd_display

Overview:
Downstream consumer of the BMP180 sensor controller's results. It takes the signed temperature (0.1 degC units) or the signed pressure (Pa) and converts it into six BCD digits. The conversion is a sequential shift-add-3 (double-dabble) engine. Results are decoded onto six active-low 7-segment displays (HEX5..HEX0) with optional leading-zero blanking and a minus sign. A conversion starts on a start pulse, typically the controller's ack, and completes with a one-cycle done pulse.

Parameters:
LZ_BLANK, 1, 1 = blank leading zeros, 0 = show all six digits
N_BITS, 19, magnitude width and iteration count (fixed, both quantities)

Ports:
CLK  input  1  system clock (50 MHz)
RST  input  1  asynchronous, active-high reset
I_START  input  1  one-cycle request; sampled only in IDLE
I_SEL  input  1  0 = temperature, 1 = pressure; sampled with I_START
I_T_VALUE  input  16  signed temperature, 0.1 degC
I_P_VALUE  input  19  signed pressure, Pa
O_BUSY  output  1  high while state != IDLE
O_DONE  output  1  one-cycle pulse when outputs update
O_SIGN  output  1  latched sign of the converted value
O_BCD  output  24  six BCD digits, [23:20] = most significant
O_HEX0..O_HEX5  output  7 each  segments gfedcba, active-low, HEX0 = least significant

Behaviour:
- Reset, asynchronous: state IDLE; O_BUSY=0, O_DONE=0, O_SIGN=0, O_BCD=0. All O_HEXn = 7'b1111111 (blank). Internal shift register and counter cleared. Reset mid-conversion aborts the conversion; no O_DONE is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, I_START=1 at edge k:
  - Select the operand by I_SEL; temperature is sign-extended to 19 bits.
  - O_SIGN_next = operand MSB.
  - Magnitude = two's-complement absolute value, 19-bit unsigned. -32768 gives 32768; -262144 gives 262144; no overflow.
  - Load the 24-bit BCD accumulator with 0 and the counter with N_BITS-1. Go to SHIFT.
- SHIFT, edges k+1..k+19, one iteration per cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then shift {bcd, mag} left by 1.
  - Counter decrements; at 0 go to DONE.
- DONE, edge k+20:
  - Register O_BCD and O_SIGN.
  - Register all O_HEXn from the new values.
  - Assert O_DONE for exactly that cycle; return to IDLE.
- O_BUSY is high for cycles k+1..k+20 and low again from k+21.
- Latency: I_START to O_DONE = 20 cycles. A back-to-back I_START is accepted at edge k+21 at the earliest.
- I_START while busy is ignored and not queued. Inputs may change freely during a conversion; only edge-k values are used.
- O_BCD/O_SIGN/O_HEXn hold their value between conversions.
- Segment encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
  - Non-BCD nibbles decode to blank.
- Blanking, LZ_BLANK=1: digits above the most significant nonzero digit are blank. HEX0 is always shown, so 0 displays as a single "0".
- Minus sign:
  - If O_SIGN=1, minus is drawn on the digit immediately left of the most significant nonzero digit.
  - If that digit is HEX5 occupied (value >= 100000), no minus is drawn; the sign is only on O_SIGN.
  - With LZ_BLANK=0, minus replaces HEX5 only when digit5 = 0.
- Max magnitude 262144 fits in six digits; no overflow case exists.

Decomposition:
- Shared package (bmp180_pkg):
  - FSM state encoding
  - N_DIGITS=6
  - segment constants SEG_BLANK and SEG_MINUS
  - digit-to-segment function or constant table
- One sub-module: bcd_to_7seg, a combinational nibble to active-low segments decoder, instantiated six times. The minus/blank override is applied in the parent before the output registers.

Test Plan:
1. RST pulse mid-SHIFT (cycle k+8) -> O_BUSY=0 immediately, O_DONE never pulses, O_BCD=0, all HEX=1111111.
2. I_SEL=0, I_T_VALUE=250 -> O_DONE at k+20, O_BCD=24'h000250, O_SIGN=0. HEX2..0 = "2","5","0"; HEX5..3 blank.
3. I_SEL=0, I_T_VALUE=-15 -> O_BCD=24'h000015, O_SIGN=1. HEX1..0 = "1","5"; HEX2 = minus; HEX5..3 blank.
4. I_SEL=1, I_P_VALUE=101325 -> O_BCD=24'h101325, all six digits shown. Then I_P_VALUE=-262144 -> O_BCD=24'h262144, O_SIGN=1, HEX5 = "2", no minus.
5. I_START repeated at k+5 and k+20 -> both ignored, single O_DONE at k+20. I_START at k+21 accepted, next O_DONE at k+41.
6. Value 0 with LZ_BLANK=1 -> HEX0="0", others blank. Same value with LZ_BLANK=0 -> all six HEX show "0".
